sd_card_dat: RTL and testbench



---
 rtl/sd_card_dat_pkg.sv | 42 ++++
 rtl/sd_crc16.sv | 30 +++
 rtl/sd_card_dat.sv | 233 +++++++++++++++++++++++
 tb/tb_sd_card_dat.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/sd_card_dat_pkg.sv
// Shared constants for the SD card DAT-line block engine:
// state encodings, CRC16 polynomial, write status tokens and helpers.
package sd_card_dat_pkg;

   typedef enum logic [3:0] {
      IDLE,
      TX_START,
      TX_DATA,
      TX_CRC,
      TX_END,
      RX_WAIT,
      RX_DATA,
      RX_CRC,
      RX_END,
      ST_TOKEN,
      ST_BUSY
   } state_t;

   // x^16 + x^12 + x^5 + 1
   localparam logic [15:0] CRC_POLY = 16'h1021;

   localparam logic [2:0] TOK_OK  = 3'b010;
   localparam logic [2:0] TOK_ERR = 3'b101;

   function automatic logic [15:0] crc16_step(
      input logic [15:0] c,
      input logic        d
   );
      logic fb;
      fb = c[15] ^ d;
      return {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
   endfunction

   // 1-bit mode carries data on lane 3 only; idle lanes sit at 1
   function automatic logic [3:0] lane_drive(
      input logic       m,
      input logic [3:0] b
   );
      return m ? b : {b[3], 3'b111};
   endfunction

endpackage

// File: rtl/sd_crc16.sv
// Serial CRC16 (one bit per clock) with synchronous clear and enable.
// Exposes the next value so callers can use the final CRC without a bubble.
module sd_crc16
   import sd_card_dat_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        i_clr,
   input  logic        i_en,
   input  logic        i_din,
   output logic [15:0] o_crc,
   output logic [15:0] o_crc_nxt
);

   logic [15:0] r_crc;

   assign o_crc     = r_crc;
   assign o_crc_nxt = crc16_step(r_crc, i_din);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_crc <= 16'h0000;
      end else if (i_clr) begin
         r_crc <= 16'h0000;
      end else if (i_en) begin
         r_crc <= o_crc_nxt;
      end
   end

endmodule

// File: rtl/sd_card_dat.sv
// SD card DAT-line engine: sends read blocks, receives write blocks,
// checks per-lane CRC16 and answers writes with a status token and busy.
module sd_card_dat
   import sd_card_dat_pkg::*;
#(
   parameter int BLOCK_WORDS = 4,
   parameter int BUSY_CYCLES = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        direction,
   input  logic        mode,
   input  logic [3:0]  dat_i,
   output logic [3:0]  dat_o,
   output logic        dat_oe,
   input  logic [31:0] tx_word,
   output logic        tx_word_req,
   output logic [31:0] rx_word,
   output logic        rx_word_valid,
   output logic        done,
   output logic        crc_err
);

   localparam logic [15:0] LAST_WORD = 16'(BLOCK_WORDS - 1);
   localparam logic [15:0] LAST_BUSY = 16'(BUSY_CYCLES - 1);

   state_t      r_state;
   logic        r_mode;
   logic [31:0] r_sh;
   logic [4:0]  r_beat;
   logic [15:0] r_word;
   logic [15:0] r_cnt;
   logic [3:0]  r_tok;
   logic [15:0] r_csh [4];

   logic [15:0] w_crc     [4];
   logic [15:0] w_crc_nxt [4];
   logic [3:0]  w_nxt_msb;
   logic [3:0]  w_csh_msb;
   logic [3:0]  w_crc_bit;
   logic [3:0]  w_crc_din;
   logic        w_crc_en;
   logic        w_crc_clr;
   logic [4:0]  w_last;
   logic [3:0]  w_act;
   logic [31:0] w_rx_sh;
   logic [31:0] w_tx_sh;
   logic [31:0] w_ld_sh;
   logic        w_end_bad;

   assign w_crc_en  = (r_state == TX_DATA) || (r_state == RX_DATA);
   assign w_crc_clr = (r_state == IDLE);
   assign w_crc_din = (r_state == TX_DATA) ? dat_o : dat_i;
   assign w_last    = r_mode ? 5'd7 : 5'd31;
   assign w_act     = r_mode ? 4'hF : 4'h8;
   assign w_end_bad = |(~dat_i & w_act);

   assign w_rx_sh = r_mode ? {r_sh[27:0], dat_i}
                           : {r_sh[30:0], dat_i[3]};
   assign w_tx_sh = r_mode ? {r_sh[27:0], 4'h0}
                           : {r_sh[30:0], 1'b0};
   assign w_ld_sh = r_mode ? {tx_word[27:0], 4'h0}
                           : {tx_word[30:0], 1'b0};

   for (genvar l = 0; l < 4; l++) begin : g_lane
      sd_crc16 u_crc (
         .clk       (clk),
         .reset     (reset),
         .i_clr     (w_crc_clr),
         .i_en      (w_crc_en),
         .i_din     (w_crc_din[l]),
         .o_crc     (w_crc[l]),
         .o_crc_nxt (w_crc_nxt[l])
      );
      assign w_nxt_msb[l] = w_crc_nxt[l][15];
      assign w_csh_msb[l] = r_csh[l][15];
      assign w_crc_bit[l] = w_crc[l][4'd15 - r_cnt[3:0]];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= IDLE;
         r_mode        <= 1'b0;
         r_sh          <= 32'h0;
         r_beat        <= 5'd0;
         r_word        <= 16'h0;
         r_cnt         <= 16'h0;
         r_tok         <= 4'h0;
         for (int l = 0; l < 4; l++) r_csh[l] <= 16'h0;
         dat_o         <= 4'hF;
         dat_oe        <= 1'b0;
         tx_word_req   <= 1'b0;
         rx_word       <= 32'h0;
         rx_word_valid <= 1'b0;
         done          <= 1'b0;
         crc_err       <= 1'b0;
      end else begin
         tx_word_req   <= 1'b0;
         rx_word_valid <= 1'b0;
         done          <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (start) begin
                  crc_err <= 1'b0;
                  r_mode  <= mode;
                  r_beat  <= 5'd0;
                  r_word  <= 16'h0;
                  r_cnt   <= 16'h0;
                  if (direction) begin
                     r_state     <= TX_START;
                     dat_oe      <= 1'b1;
                     dat_o       <= mode ? 4'h0 : 4'h7;
                     tx_word_req <= 1'b1;
                  end else begin
                     r_state <= RX_WAIT;
                  end
               end
            end
            TX_START: begin
               r_sh    <= w_ld_sh;
               dat_o   <= lane_drive(r_mode, tx_word[31:28]);
               r_beat  <= 5'd0;
               r_word  <= 16'h0;
               r_state <= TX_DATA;
            end
            TX_DATA: begin
               if (r_beat == w_last) begin
                  if (r_word == LAST_WORD) begin
                     // final CRC includes the beat on the wire right now
                     for (int l = 0; l < 4; l++)
                        r_csh[l] <= {w_crc_nxt[l][14:0], 1'b0};
                     dat_o   <= lane_drive(r_mode, w_nxt_msb);
                     r_cnt   <= 16'h0;
                     r_state <= TX_CRC;
                  end else begin
                     r_sh   <= w_ld_sh;
                     dat_o  <= lane_drive(r_mode, tx_word[31:28]);
                     r_beat <= 5'd0;
                     r_word <= r_word + 16'h1;
                  end
               end else begin
                  r_sh   <= w_tx_sh;
                  dat_o  <= lane_drive(r_mode, r_sh[31:28]);
                  r_beat <= r_beat + 5'd1;
                  if ((r_beat + 5'd1 == w_last) && (r_word != LAST_WORD))
                     tx_word_req <= 1'b1;
               end
            end
            TX_CRC: begin
               if (r_cnt == 16'd15) begin
                  dat_o   <= 4'hF;
                  r_state <= TX_END;
               end else begin
                  dat_o <= lane_drive(r_mode, w_csh_msb);
                  for (int l = 0; l < 4; l++)
                     r_csh[l] <= {r_csh[l][14:0], 1'b0};
                  r_cnt <= r_cnt + 16'h1;
               end
            end
            TX_END: begin
               dat_oe  <= 1'b0;
               dat_o   <= 4'hF;
               done    <= 1'b1;
               r_state <= IDLE;
            end
            RX_WAIT: begin
               if (!dat_i[3]) begin
                  r_beat  <= 5'd0;
                  r_word  <= 16'h0;
                  r_state <= RX_DATA;
               end
            end
            RX_DATA: begin
               r_sh <= w_rx_sh;
               if (r_beat == w_last) begin
                  rx_word       <= w_rx_sh;
                  rx_word_valid <= 1'b1;
                  r_beat        <= 5'd0;
                  if (r_word == LAST_WORD) begin
                     r_cnt   <= 16'h0;
                     r_state <= RX_CRC;
                  end else begin
                     r_word <= r_word + 16'h1;
                  end
               end else begin
                  r_beat <= r_beat + 5'd1;
               end
            end
            RX_CRC: begin
               if (|((dat_i ^ w_crc_bit) & w_act)) crc_err <= 1'b1;
               if (r_cnt == 16'd15) begin
                  r_state <= RX_END;
               end else begin
                  r_cnt <= r_cnt + 16'h1;
               end
            end
            RX_END: begin
               crc_err <= crc_err | w_end_bad;
               r_tok   <= (crc_err | w_end_bad) ? {TOK_ERR, 1'b1}
                                                : {TOK_OK, 1'b1};
               dat_oe  <= 1'b1;
               dat_o   <= 4'h7;
               r_cnt   <= 16'h0;
               r_state <= ST_TOKEN;
            end
            ST_TOKEN: begin
               if (r_cnt == 16'd4) begin
                  dat_o   <= 4'h7;
                  r_cnt   <= 16'h0;
                  r_state <= ST_BUSY;
               end else begin
                  dat_o <= {r_tok[3], 3'b111};
                  r_tok <= {r_tok[2:0], 1'b1};
                  r_cnt <= r_cnt + 16'h1;
               end
            end
            ST_BUSY: begin
               if (r_cnt == LAST_BUSY) begin
                  dat_oe  <= 1'b0;
                  dat_o   <= 4'hF;
                  done    <= 1'b1;
                  r_state <= IDLE;
               end else begin
                  r_cnt <= r_cnt + 16'h1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sd_card_dat.sv
// Directed bench for sd_card_dat: reads in both bus widths, writes with
// good and corrupted CRC, ignored start and reset abort.
module tb_sd_card_dat;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        direction;
   logic        mode;
   logic [3:0]  dat_i;
   logic [3:0]  dat_o;
   logic        dat_oe;
   logic [31:0] tx_word;
   logic        tx_word_req;
   logic [31:0] rx_word;
   logic        rx_word_valid;
   logic        done;
   logic        crc_err;

   int vectors = 0;
   int errors  = 0;

   logic [31:0] words [4];
   logic [3:0]  body [$];
   logic [3:0]  got  [$];
   logic [3:0]  expq [$];
   logic [3:0]  hostq [$];
   logic [31:0] rxq  [$];
   int          dones;
   int          reqs;

   always #5 clk = ~clk;

   sd_card_dat #(.BLOCK_WORDS(4), .BUSY_CYCLES(8)) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .direction     (direction),
      .mode          (mode),
      .dat_i         (dat_i),
      .dat_o         (dat_o),
      .dat_oe        (dat_oe),
      .tx_word       (tx_word),
      .tx_word_req   (tx_word_req),
      .rx_word       (rx_word),
      .rx_word_valid (rx_word_valid),
      .done          (done),
      .crc_err       (crc_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // CRC16 x^16+x^12+x^5+1 written out tap by tap
   function automatic logic [15:0] mstep(input logic [15:0] c,
                                         input logic d);
      logic        fb;
      logic [15:0] n;
      fb    = c[15] ^ d;
      n     = c << 1;
      n[0]  = fb;
      n[5]  = c[4] ^ fb;
      n[12] = c[11] ^ fb;
      return n;
   endfunction

   // Data beats followed by 16 per-lane CRC beats, as seen on the bus
   task automatic build(input logic m);
      logic [15:0] c [4];
      logic [3:0]  b;
      body.delete();
      for (int l = 0; l < 4; l++) c[l] = 16'h0;
      for (int w = 0; w < 4; w++) begin
         for (int k = 0; k < (m ? 8 : 32); k++) begin
            if (m) b = words[w][31-4*k -: 4];
            else   b = {words[w][31-k], 3'b111};
            body.push_back(b);
            for (int l = 0; l < 4; l++) c[l] = mstep(c[l], b[l]);
         end
      end
      for (int i = 0; i < 16; i++) begin
         for (int l = 0; l < 4; l++) b[l] = c[l][15-i];
         if (!m) b[2:0] = 3'b111;
         body.push_back(b);
      end
   endtask

   task automatic run_read(input logic m, input logic glitch,
                           input string tag);
      int idx;
      build(m);
      expq.delete();
      expq.push_back(m ? 4'h0 : 4'h7);
      foreach (body[i]) expq.push_back(body[i]);
      expq.push_back(4'hF);
      got.delete();
      dones = 0;
      reqs  = 0;
      idx   = 0;
      @(negedge clk);
      start = 1'b1; direction = 1'b1; mode = m;
      @(negedge clk);
      start = 1'b0; direction = 1'b0; mode = ~m;
      for (int i = 0; i < expq.size() + 12; i++) begin
         if (tx_word_req) begin
            reqs++;
            tx_word = (idx < 4) ? words[idx] : 32'hDEADBEEF;
            idx++;
         end
         if (dat_oe) got.push_back(dat_o);
         if (done) dones++;
         start = glitch && (i == 10);
         @(negedge clk);
      end
      start = 1'b0;
      chk($sformatf("%s_len", tag), got.size(), expq.size());
      for (int i = 0; i < expq.size(); i++)
         chk($sformatf("%s_beat%0d", tag, i),
             (i < got.size()) ? {28'h0, got[i]} : 32'hx,
             {28'h0, expq[i]});
      chk($sformatf("%s_reqs", tag), reqs, 4);
      chk($sformatf("%s_done", tag), dones, 1);
      chk($sformatf("%s_oe_off", tag), dat_oe, 1'b0);
   endtask

   task automatic run_write(input logic flip, input string tag);
      logic [4:0] tk;
      build(1'b1);
      hostq.delete();
      hostq.push_back(4'hF);
      hostq.push_back(4'hF);
      hostq.push_back(4'h0);
      foreach (body[i]) hostq.push_back(body[i]);
      hostq.push_back(4'hF);
      if (flip) hostq[3+32] = hostq[3+32] ^ 4'b0010;
      got.delete();
      rxq.delete();
      dones = 0;
      @(negedge clk);
      start = 1'b1; direction = 1'b0; mode = 1'b1;
      @(negedge clk);
      start = 1'b0; direction = 1'b1; mode = 1'b0;
      for (int i = 0; i < hostq.size() + 30; i++) begin
         if (rx_word_valid) rxq.push_back(rx_word);
         if (dat_oe) got.push_back(dat_o);
         if (done) dones++;
         dat_i = (i < hostq.size()) ? hostq[i] : 4'hF;
         @(negedge clk);
      end
      tk = flip ? 5'b01011 : 5'b00101;
      chk($sformatf("%s_nwords", tag), rxq.size(), 4);
      for (int i = 0; i < 4; i++)
         chk($sformatf("%s_word%0d", tag, i),
             (i < rxq.size()) ? rxq[i] : 32'hx, words[i]);
      chk($sformatf("%s_len", tag), got.size(), 13);
      for (int j = 0; j < 13; j++)
         chk($sformatf("%s_resp%0d", tag, j),
             (j < got.size()) ? {28'h0, got[j]} : 32'hx,
             (j < 5) ? {28'h0, tk[4-j], 3'b111} : 32'h7);
      chk($sformatf("%s_crc_err", tag), crc_err, flip);
      chk($sformatf("%s_done", tag), dones, 1);
   endtask

   initial begin
      words[0] = 32'h01234567;
      words[1] = 32'h89ABCDEF;
      words[2] = 32'hFEDCBA98;
      words[3] = 32'h76543210;
      reset     = 1'b1;
      start     = 1'b0;
      direction = 1'b0;
      mode      = 1'b0;
      dat_i     = 4'hF;
      tx_word   = 32'h0;
      repeat (2) @(negedge clk);
      chk("rst_oe",    dat_oe,        1'b0);
      chk("rst_dat",   dat_o,         4'hF);
      chk("rst_req",   tx_word_req,   1'b0);
      chk("rst_rx",    rx_word,       32'h0);
      chk("rst_rxv",   rx_word_valid, 1'b0);
      chk("rst_done",  done,          1'b0);
      chk("rst_crc",   crc_err,       1'b0);
      reset = 1'b0;
      @(negedge clk);

      run_read(1'b1, 1'b0, "rd4");
      run_read(1'b0, 1'b0, "rd1");
      run_write(1'b0, "wr_ok");
      run_write(1'b1, "wr_bad");
      run_read(1'b1, 1'b1, "rd_glitch");
      chk("rd_glitch_crc_clr", crc_err, 1'b0);

      // abort a write in the middle of its data phase
      @(negedge clk);
      start = 1'b1; direction = 1'b0; mode = 1'b1;
      @(negedge clk);
      start = 1'b0;
      dat_i = 4'h0;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         dat_i = 4'(i + 3);
         @(negedge clk);
      end
      reset = 1'b1;
      #1;
      chk("abort_oe",  dat_oe, 1'b0);
      chk("abort_dat", dat_o,  4'hF);
      @(negedge clk);
      reset = 1'b0;
      dat_i = 4'hF;
      dones = 0;
      for (int i = 0; i < 20; i++) begin
         if (done) dones++;
         @(negedge clk);
      end
      chk("abort_no_done", dones,  0);
      chk("abort_oe_idle", dat_oe, 1'b0);
      chk("abort_rx",      rx_word, 32'h0);
      run_read(1'b1, 1'b0, "rd_after_rst");

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, errors);
      $finish;
   end

endmodule
